apple2_sram_arbiter: RTL and testbench
======================================

# apple2_sram_arbiter

Shares the single external 8-bit asynchronous SRAM between three requesters: the CPU path (already translated through the language-card/Saturn bank mapping into an 18-bit RAM address), video scan-out fetch, and the loader DMA that writes ROM and disk images.
- Sits between the bank-mapping logic and the SRAM pins.
- Serialises accesses by fixed priority with a loader anti-starvation rule.
- Generates SRAM strobe timing in mclk28 cycles.

## Interface
Parameters:
- ACCESS_CYCLES, 3, mclk28 cycles per SRAM access (legal 3..15)
- LDR_STARVE, 4, consecutive lost arbitrations after which the loader outranks the CPU (legal 1..15)

Ports:
- mclk28  in  1  system clock, 28 MHz
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request, level, held until ack
- vid_addr  in  18  video SRAM address, zero-extended to 19 bits
- vid_rdata  out  8  video read data
- vid_ack  out  1  one-cycle completion pulse
- cpu_req  in  1  CPU request, level, held until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  18  mapped RAM address, zero-extended to 19 bits
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data
- cpu_ack  out  1  one-cycle completion pulse
- ldr_req  in  1  loader write request, level, held until ack
- ldr_addr  in  19  loader SRAM address, full range
- ldr_wdata  in  8  loader write data
- ldr_ack  out  1  one-cycle completion pulse
- sram_addr  out  19  SRAM address
- sram_dq_o  out  8  SRAM write data
- sram_dq_oe  out  1  SRAM data-bus drive enable
- sram_dq_i  in  8  SRAM read data
- sram_we_n  out  1  SRAM write strobe, active low
- sram_oe_n  out  1  SRAM output enable, active low
- busy  out  1  high while in ACCESS or DONE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:** requests are sampled at each edge.
  - Default priority: vid > cpu > ldr.
  - If the starvation counter is at or above LDR_STARVE, priority is vid > ldr > cpu.
  - On grant, address, write data and direction are registered.
  - sram_addr, sram_dq_o and sram_dq_oe become valid in the first ACCESS cycle.
  - The phase counter loads ACCESS_CYCLES-1.
  - Next state is ACCESS.
- **ACCESS (read):**
  - sram_oe_n is low for every ACCESS cycle.
  - SRAM data is captured into the granted requester's rdata on the edge that ends the last ACCESS cycle (counter = 0).
- **ACCESS (write):**
  - sram_dq_oe is high for all ACCESS cycles.
  - sram_we_n is low only for the middle cycles (phase 1 through ACCESS_CYCLES-2), which gives one cycle of address/data setup and one cycle of hold.
  - sram_oe_n stays high.
- **DONE:**
  - Exactly one of vid_ack, cpu_ack, ldr_ack is high for one cycle.
  - No grant is made in DONE.
  - Next state is IDLE.
- **Request release:** a requester must drop req by the IDLE cycle that follows its ack. A req still high there is a new request.
- **rdata hold:** each rdata holds its value until the next read completes for that requester.
- **Starvation counter (3..4 bits, saturating):**
  - Increments when the loader is requesting but the grant goes to cpu.
  - Clears on a loader grant, or when ldr_req is low in IDLE.
  - Video grants do not change it.
- **Simultaneous requests:** all three high in IDLE with the counter at 0 grant video.
- **Address wrap:** none. Addresses are used as given.

## Timing
- Reset values (asynchronous):
  - FSM in IDLE, counters 0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
  - sram_addr=0, sram_dq_o=0.
  - All rdata=0, all acks=0, busy=0.
- Reset asserted mid-access:
  - Strobes are released immediately.
  - The aborted access is never acked.
  - After release the FSM starts from IDLE.
- Latency, with req sampled high in IDLE at edge k:
  - ACCESS occupies cycles k+1..k+ACCESS_CYCLES.
  - ack is high in cycle k+ACCESS_CYCLES+1.
  - Default: 4 cycles from grant edge to ack.
- Throughput: one access per ACCESS_CYCLES+2 cycles (5 by default), so back-to-back grants are 5 cycles apart.
- sram_we_n never goes low in the same cycle that sram_addr changes.

## Configuration
- Macro: SRAM_ARB_LOADER_EN.
- Defined:
  - The loader port and the starvation counter exist as described.
- Undefined:
  - The ldr_* ports remain.
  - ldr_req is ignored.
  - ldr_ack is tied to 0.
  - The starvation logic is removed.
  - Arbitration is vid > cpu only.

## Test plan
- **CPU write then read:** cpu write 0x2A to 0x00C00, then a cpu read of the same address.
  - Write: sram_we_n low for exactly 1 cycle; cpu_ack in cycle 4 after grant.
  - Read: cpu_rdata=0x2A with cpu_ack.
- **Simultaneous requests:** vid, cpu and ldr all requesting in the same IDLE cycle.
  - Grants in order vid, cpu, ldr.
  - Acks spaced 5 cycles apart.
- **Loader starvation:** cpu_req held continuously (re-raised after each ack) while ldr_req is held.
  - The loader is granted after exactly 4 cpu grants.
  - The counter returns to 0 after the loader grant.
- **Reset mid-write:** reset_n pulsed low during ACCESS phase 1.
  - sram_we_n=1 and sram_dq_oe=0 asynchronously.
  - No ack is generated.
  - The next request completes normally.
- **Held request:** vid_req kept high past its ack.
  - A second video access starts in the IDLE cycle after DONE.
  - vid_rdata updates only on the second ack.
- **Loader compiled out:** build without SRAM_ARB_LOADER_EN and drive ldr_req=1 constantly.
  - ldr_ack stays 0.
  - sram_we_n is never asserted for ldr_addr.

Source files
------------

// File: rtl/apple2_sram_arbiter.sv
// apple2_sram_arbiter
// Shares one external 8-bit asynchronous SRAM between video scan-out,
// the bank-mapped CPU path and the image loader DMA. Requests are served
// one at a time by fixed priority (vid > cpu > ldr). The loader moves
// ahead of the CPU once it has lost LDR_STARVE arbitrations in a row.
// Every access takes ACCESS_CYCLES mclk28 cycles, followed by a one-cycle
// DONE state that carries the ack pulse.
//
// Optional feature macro: SRAM_ARB_LOADER_EN
//   defined   : loader port and starvation counter are active
//   undefined : ldr_req is ignored, ldr_ack is held at 0, and arbitration
//               is vid > cpu only
//
// Ports
//   mclk28, reset_n           clock, asynchronous active-low reset
//   vid_req/addr/rdata/ack    video read port
//   cpu_req/we/addr/wdata/
//   cpu_rdata/ack             CPU read/write port
//   ldr_req/addr/wdata/ack    loader write port (19-bit address)
//   sram_addr, sram_dq_o,
//   sram_dq_oe, sram_dq_i,
//   sram_we_n, sram_oe_n      SRAM pins (all outputs registered)
//   busy                      high while in ACCESS or DONE
module apple2_sram_arbiter #(
  parameter int ACCESS_CYCLES = 3,
  parameter int LDR_STARVE    = 4
) (
  input  logic        mclk28,
  input  logic        reset_n,
  input  logic        vid_req,
  input  logic [17:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [17:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic [18:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [7:0]  sram_dq_i,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {G_VID = 2'd0, G_CPU = 2'd1, G_LDR = 2'd2} gnt_t;

  // Phase counts down: PH_FIRST is the setup cycle, 0 is the hold cycle.
  localparam logic [3:0] PH_FIRST   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] PH_WE_LAST = 4'(ACCESS_CYCLES - 2);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_phase, w_phase_nxt;
  gnt_t        r_gnt, w_gnt_nxt;
  logic        r_we, w_we_nxt;
  logic [18:0] w_addr_nxt;
  logic [7:0]  w_wdata_nxt;
  logic        w_ldr_req;
  logic        w_ldr_first;
  logic        w_acc_nxt;
  logic        w_done_nxt;

`ifdef SRAM_ARB_LOADER_EN
  logic [3:0]  r_starve, w_starve_nxt;

  assign w_ldr_req   = ldr_req;
  assign w_ldr_first = (r_starve >= 4'(LDR_STARVE));
`else
  logic        w_unused_ldr;

  assign w_ldr_req    = 1'b0;
  assign w_ldr_first  = 1'b0;
  assign w_unused_ldr = ldr_req;
`endif

  assign w_acc_nxt  = (w_state_nxt == S_ACCESS);
  assign w_done_nxt = (w_state_nxt == S_DONE);

  // Next-state logic: arbitration in IDLE, phase countdown in ACCESS.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_gnt_nxt   = r_gnt;
    w_we_nxt    = r_we;
    w_addr_nxt  = sram_addr;
    w_wdata_nxt = sram_dq_o;
    case (r_state)
      S_IDLE: begin
        if (vid_req) begin
          w_state_nxt = S_ACCESS;
          w_phase_nxt = PH_FIRST;
          w_gnt_nxt   = G_VID;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = {1'b0, vid_addr};
        end else if (w_ldr_req && (w_ldr_first || !cpu_req)) begin
          w_state_nxt = S_ACCESS;
          w_phase_nxt = PH_FIRST;
          w_gnt_nxt   = G_LDR;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = ldr_addr;
          w_wdata_nxt = ldr_wdata;
        end else if (cpu_req) begin
          w_state_nxt = S_ACCESS;
          w_phase_nxt = PH_FIRST;
          w_gnt_nxt   = G_CPU;
          w_we_nxt    = cpu_we;
          w_addr_nxt  = {1'b0, cpu_addr};
          w_wdata_nxt = cpu_wdata;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (r_phase == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_phase_nxt = r_phase - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef SRAM_ARB_LOADER_EN
  // Loader starvation counter: counts CPU wins while the loader waits.
  always_comb begin
    if (r_state != S_IDLE) begin
      w_starve_nxt = r_starve;
    end else if (!ldr_req) begin
      w_starve_nxt = 4'd0;
    end else if (w_acc_nxt && (w_gnt_nxt == G_LDR)) begin
      w_starve_nxt = 4'd0;
    end else if (w_acc_nxt && (w_gnt_nxt == G_CPU) && (r_starve != 4'hF)) begin
      w_starve_nxt = r_starve + 4'd1;
    end else begin
      w_starve_nxt = r_starve;
    end
  end
`endif

  // FSM state, phase counter, grant and direction registers.
  always_ff @(posedge mclk28 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_phase  <= 4'd0;
      r_gnt    <= G_VID;
      r_we     <= 1'b0;
`ifdef SRAM_ARB_LOADER_EN
      r_starve <= 4'd0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_gnt    <= w_gnt_nxt;
      r_we     <= w_we_nxt;
`ifdef SRAM_ARB_LOADER_EN
      r_starve <= w_starve_nxt;
`endif
    end
  end

  // Registered SRAM strobes, acks and read-data capture, all derived from
  // next-state values so they line up with the state they belong to.
  always_ff @(posedge mclk28 or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr  <= 19'd0;
      sram_dq_o  <= 8'd0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      busy       <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
      vid_rdata  <= 8'd0;
      cpu_rdata  <= 8'd0;
    end else begin
      sram_addr  <= w_addr_nxt;
      sram_dq_o  <= w_wdata_nxt;
      sram_dq_oe <= w_acc_nxt && w_we_nxt;
      sram_oe_n  <= !(w_acc_nxt && !w_we_nxt);
      // First and last ACCESS cycles give address/data setup and hold.
      sram_we_n  <= !(w_acc_nxt && w_we_nxt &&
                      (w_phase_nxt >= 4'd1) && (w_phase_nxt <= PH_WE_LAST));
      busy       <= (w_state_nxt != S_IDLE);
      vid_ack    <= w_done_nxt && (w_gnt_nxt == G_VID);
      cpu_ack    <= w_done_nxt && (w_gnt_nxt == G_CPU);
`ifdef SRAM_ARB_LOADER_EN
      ldr_ack    <= w_done_nxt && (w_gnt_nxt == G_LDR);
`else
      ldr_ack    <= 1'b0;
`endif
      if ((r_state == S_ACCESS) && (r_phase == 4'd0) && !r_we) begin
        case (r_gnt)
          G_VID:   vid_rdata <= sram_dq_i;
          G_CPU:   cpu_rdata <= sram_dq_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apple2_sram_arbiter.sv
// Scoreboard bench for apple2_sram_arbiter: stimulus pushes expected
// completions (requester, read data) into a queue; a monitor pops and
// compares on every ack. Works with or without SRAM_ARB_LOADER_EN.
module tb_apple2_sram_arbiter;

  logic        mclk28 = 1'b0;
  logic        reset_n = 1'b0;
  logic        vid_req = 1'b0;
  logic [17:0] vid_addr = 18'd0;
  logic [7:0]  vid_rdata;
  logic        vid_ack;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [17:0] cpu_addr = 18'd0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        ldr_req = 1'b0;
  logic [18:0] ldr_addr = 19'h40000;
  logic [7:0]  ldr_wdata = 8'h55;
  logic        ldr_ack;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dq_o;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_i = 8'd0;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        busy;

  apple2_sram_arbiter dut (
    .mclk28(mclk28), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .busy(busy)
  );

  always #5 mclk28 = ~mclk28;

  typedef struct {
    int         id;   // 0 vid, 1 cpu, 2 ldr
    bit         rd;
    logic [7:0] d;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mem [logic [18:0]];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  logic [18:0] prev_addr = 19'd0;
  int          t_vid, t_cpu, t_ldr;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic bit ack_of(input int id);
    case (id)
      0:       return vid_ack;
      1:       return cpu_ack;
      default: return ldr_ack;
    endcase
  endfunction

  always @(posedge mclk28) cyc++;

  // SRAM model: write on clock edges while we_n is low, read data presented
  // on the falling edge so it is stable at the capturing rising edge.
  always @(posedge mclk28) begin
    if (reset_n && !sram_we_n) mem[sram_addr] = sram_dq_o;
  end
  always @(negedge mclk28) begin
    if (!sram_oe_n && mem.exists(sram_addr)) sram_dq_i = mem[sram_addr];
    else sram_dq_i = 8'h00;
  end

  // Write strobe checks: address stable under we_n, no loader writes when
  // the loader is compiled out.
  always @(negedge mclk28) begin
    if (reset_n && !sram_we_n) begin
      we_cnt++;
      check("we_addr_stable", int'(sram_addr), int'(prev_addr));
`ifndef SRAM_ARB_LOADER_EN
      check("no_ldr_write", int'(sram_addr == 19'h40000), 0);
`endif
    end
    prev_addr = sram_addr;
  end

  // Scoreboard monitor.
  int         mon_n, mon_id;
  exp_t       mon_e;
  logic [7:0] mon_rd;
  always @(negedge mclk28) begin
    if (reset_n === 1'b1) begin
      mon_n = int'(vid_ack) + int'(cpu_ack) + int'(ldr_ack);
      if (mon_n != 0) begin
        check("ack_onehot", mon_n, 1);
        mon_id = vid_ack ? 0 : (cpu_ack ? 1 : 2);
        if (sbq.size() == 0) begin
          check("unexpected_ack", mon_id, -1);
        end else begin
          mon_e = sbq.pop_front();
          check("ack_id", mon_id, mon_e.id);
          if (mon_e.rd) begin
            mon_rd = (mon_id == 0) ? vid_rdata : cpu_rdata;
            check("rdata", int'(mon_rd), int'(mon_e.d));
          end
        end
      end
    end
  end

  task automatic push(input int id, input bit rd, input logic [7:0] d);
    exp_t e;
    e.id = id; e.rd = rd; e.d = d;
    sbq.push_back(e);
  endtask

  // Single CPU access; returns negedges from request to ack (grant edge
  // is the first rising edge after the request is raised).
  task automatic do_cpu(input logic we, input logic [17:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd, output int lat);
    push(1, !we, exp_rd);
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge mclk28);
      if (cpu_ack) begin
        lat = i;
        break;
      end
    end
    cpu_req = 1'b0;
    if (lat < 0) check("cpu_timeout", 0, 1);
    @(negedge mclk28);
  endtask

  task automatic wait_ack(input int id, output int t);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge mclk28);
      if (ack_of(id)) begin
        t = cyc;
        if (id == 0) vid_req = 1'b0;
        else if (id == 1) cpu_req = 1'b0;
        else ldr_req = 1'b0;
        break;
      end
    end
    if (t < 0) check("ack_timeout", id, -1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, acks, t1, t2, ncpu, rounds;
    int runs[2];
    mem[19'h01234] = 8'h5A;
    mem[19'h02000] = 8'hC3;
`ifndef SRAM_ARB_LOADER_EN
    ldr_req = 1'b1;
`endif

    // Reset state
    @(negedge mclk28);
    @(negedge mclk28);
    check("rst_we_n", int'(sram_we_n), 1);
    check("rst_oe_n", int'(sram_oe_n), 1);
    check("rst_dq_oe", int'(sram_dq_oe), 0);
    check("rst_addr_dq", int'({sram_addr, sram_dq_o}), 0);
    check("rst_rdata", int'({vid_rdata, cpu_rdata}), 0);
    check("rst_ack_busy", int'({vid_ack, cpu_ack, ldr_ack, busy}), 0);
    reset_n = 1'b1;
    @(negedge mclk28);

    // CPU write then read
    we_cnt = 0;
    do_cpu(1'b1, 18'h00C00, 8'h2A, 8'h00, lat);
    check("cpu_wr_latency", lat, 4);
    check("cpu_wr_we_cycles", we_cnt, 1);
    do_cpu(1'b0, 18'h00C00, 8'h00, 8'h2A, lat);
    check("cpu_rd_latency", lat, 4);
    check("cpu_rd_data", int'(cpu_rdata), 8'h2A);

    // Simultaneous requests
    vid_addr = 18'h01234; vid_req = 1'b1; push(0, 1'b1, 8'h5A);
    cpu_we = 1'b0; cpu_addr = 18'h00C00; cpu_req = 1'b1; push(1, 1'b1, 8'h2A);
`ifdef SRAM_ARB_LOADER_EN
    ldr_addr = 19'h40000; ldr_wdata = 8'h55; ldr_req = 1'b1; push(2, 1'b0, 8'h00);
    fork
      wait_ack(0, t_vid);
      wait_ack(1, t_cpu);
      wait_ack(2, t_ldr);
    join
    check("cpu_ldr_spacing", t_ldr - t_cpu, 5);
    check("ldr_wr_mem", int'(mem.exists(19'h40000) ? mem[19'h40000] : 8'h00), 8'h55);
`else
    fork
      wait_ack(0, t_vid);
      wait_ack(1, t_cpu);
    join
`endif
    check("vid_cpu_spacing", t_cpu - t_vid, 5);
    @(negedge mclk28);

`ifdef SRAM_ARB_LOADER_EN
    // Loader starvation: cpu and ldr held continuously for two loader wins
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(1, 1'b1, 8'h2A);
      push(2, 1'b0, 8'h00);
    end
    cpu_we = 1'b0; cpu_addr = 18'h00C00; cpu_req = 1'b1;
    ldr_addr = 19'h40001; ldr_wdata = 8'h66; ldr_req = 1'b1;
    ncpu = 0; rounds = 0; runs[0] = -1; runs[1] = -1;
    for (int i = 0; i < 150 && rounds < 2; i++) begin
      @(negedge mclk28);
      if (cpu_ack) ncpu++;
      if (ldr_ack) begin
        runs[rounds] = ncpu;
        ncpu = 0;
        rounds++;
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    check("starve_rounds", rounds, 2);
    check("starve_cpu_run1", runs[0], 4);
    check("starve_cpu_run2", runs[1], 4);
    @(negedge mclk28);
`endif

    // Reset mid-write (ACCESS phase 1)
    cpu_we = 1'b1; cpu_addr = 18'h00C01; cpu_wdata = 8'h77; cpu_req = 1'b1;
    @(negedge mclk28);
    @(negedge mclk28);
    check("midwr_we_low", int'(sram_we_n), 0);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_we_n", int'(sram_we_n), 1);
    check("midrst_dq_oe", int'(sram_dq_oe), 0);
    check("midrst_busy", int'(busy), 0);
    cpu_req = 1'b0;
    @(negedge mclk28);
    @(negedge mclk28);
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge mclk28);
      acks += int'(vid_ack) + int'(cpu_ack) + int'(ldr_ack);
    end
    check("midrst_no_ack", acks, 0);
    do_cpu(1'b0, 18'h00C00, 8'h00, 8'h2A, lat);
    check("post_rst_latency", lat, 4);

    // Held video request: second access right after DONE
    vid_addr = 18'h01234; vid_req = 1'b1;
    push(0, 1'b1, 8'h5A);
    push(0, 1'b1, 8'hC3);
    acks = 0; t1 = 0; t2 = 0;
    for (int i = 0; i < 40 && acks < 2; i++) begin
      @(negedge mclk28);
      if (vid_ack) begin
        acks++;
        if (acks == 1) begin
          t1 = cyc;
          vid_addr = 18'h02000;
        end else begin
          t2 = cyc;
          vid_req = 1'b0;
        end
      end else if (acks == 1) begin
        check("vid_rdata_hold", int'(vid_rdata), 8'h5A);
      end
    end
    check("held_acks", acks, 2);
    check("held_spacing", t2 - t1, 5);
    check("held_final_rdata", int'(vid_rdata), 8'hC3);

    repeat (8) @(negedge mclk28);
    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
